vga_scan_fetch: RTL and testbench

- Display-side consumer of the framebuffer RAM's read port (vga_address / vga_data).
- Generates 640x480@60 Hz VGA timing from a 50 MHz clk using a /2 pixel tick.
- Fetches one 16-bit RGB565 word per displayed pixel from a 160x120 framebuffer, scaled 4x in both axes.
- Drives 8-bit RGB332 colour plus hsync/vsync to the board connector.

---
 rtl/vga_scan_fetch.sv | 152 +++++++++++++++
 tb/tb_vga_scan_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_fetch.sv
// vga_scan_fetch: 640x480@60 raster generator (50 MHz clk, /2 pixel tick) that
// fetches a 4x-scaled 160x120 RGB565 framebuffer and drives RGB332 + syncs.
`timescale 1ns/1ps
module vga_scan_fetch #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int FB_WIDTH  = H_VISIBLE / 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] base_address,
  output logic [23:0] vga_address,
  input  logic [15:0] vga_data,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0]  H_SYNC_LO  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]  H_SYNC_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0]  V_SYNC_LO  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  V_SYNC_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [23:0] FB_STEP    = 24'(FB_WIDTH);

  logic        r_pix_en;
  logic [9:0]  r_h_count;
  logic [9:0]  r_v_count;
  logic [23:0] r_row_base;
  logic        r_vis1;
  logic        r_hs1;
  logic        r_vs1;

  logic        w_h_vis;
  logic        w_v_vis;
  logic        w_h_sync;
  logic        w_v_sync;
  logic        w_h_last;
  logic        w_v_last;
  logic [23:0] w_col_off;
  logic        w_unused;

  // region decode of the current raster position
  always_comb begin
    w_h_vis   = (r_h_count < H_VIS_END);
    w_v_vis   = (r_v_count < V_VIS_END);
    w_h_sync  = (r_h_count >= H_SYNC_LO) && (r_h_count <= H_SYNC_HI);
    w_v_sync  = (r_v_count >= V_SYNC_LO) && (r_v_count <= V_SYNC_HI);
    w_h_last  = (r_h_count == H_LAST);
    w_v_last  = (r_v_count == V_LAST);
    // each framebuffer column covers four screen pixels
    w_col_off = {16'd0, r_h_count[9:2]};
  end

  // only the RGB332-relevant bits of the RGB565 word are displayed
  assign w_unused = ^{vga_data[12:11], vga_data[7:5], vga_data[2:0]};

  // pixel tick: every other clk
  always_ff @(posedge clk) begin
    if (!rst_n) r_pix_en <= 1'b0;
    else        r_pix_en <= ~r_pix_en;
  end

  // horizontal / vertical raster counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (r_pix_en) begin
      if (w_h_last) begin
        r_h_count <= '0;
        r_v_count <= w_v_last ? '0 : r_v_count + 10'd1;
      end else begin
        r_h_count <= r_h_count + 10'd1;
      end
    end
  end

  // fetch address and row base; row advances every 4th visible line, frame base latched at wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row_base  <= base_address;
      vga_address <= '0;
    end else if (r_pix_en) begin
      vga_address <= (w_h_vis && w_v_vis) ? r_row_base + w_col_off : r_row_base;
      if (w_h_last) begin
        if (w_v_last)
          r_row_base <= base_address;
        else if (w_v_vis && (r_v_count[1:0] == 2'd3))
          r_row_base <= r_row_base + FB_STEP;
      end
    end
  end

  // stage 1: visibility and sync, aligned with the address just issued
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vis1 <= 1'b0;
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
    end else if (r_pix_en) begin
      r_vis1 <= w_h_vis && w_v_vis;
      r_hs1  <= ~w_h_sync;
      r_vs1  <= ~w_v_sync;
    end
  end

  // output stage: RAM data for the stage-1 pixel has arrived by this tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (r_pix_en) begin
      hsync <= r_hs1;
      vsync <= r_vs1;
      if (r_vis1 && enable) begin
        red   <= vga_data[15:13];
        green <= vga_data[10:8];
        blue  <= vga_data[4:3];
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

  // one-clk pulse on the tick that wraps the raster to (0,0)
  always_ff @(posedge clk) begin
    if (!rst_n) frame_start <= 1'b0;
    else        frame_start <= r_pix_en && w_h_last && w_v_last;
  end

endmodule

// File: tb/tb_vga_scan_fetch.sv
// Bench for vga_scan_fetch: reduced-timing instance checked pixel-by-pixel through a
// scoreboard, plus a default-timing instance checked at line-0..5 landmarks.
`timescale 1ns/1ps
module tb_vga_scan_fetch;
  localparam int HV = 64, HF = 4, HS = 8, HB = 4, HT = HV + HF + HS + HB;
  localparam int VV = 24, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
  localparam int FBW = HV / 4;
  localparam int WAIT_MAX = 12000;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        vis;
    logic [23:0] addr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [23:0] base_address;
  logic [23:0] vga_address;
  logic [15:0] vga_data;
  logic        hsync, vsync, frame_start;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic        ram_ones;

  logic        f_enable;
  logic [23:0] f_base;
  logic [23:0] f_vga_address;
  logic [15:0] f_vga_data;
  logic        f_hsync, f_vsync, f_frame_start;
  logic [2:0]  f_red, f_green;
  logic [1:0]  f_blue;

  int n_tests = 0;
  int n_fail  = 0;
  int n = 0;
  int cyc = 0;
  int last_fs = -1;
  int m_h = -1, m_v = -1, m_f = 0;
  int f_low = 0;
  bit first_run = 1;
  bit timed_out = 0;
  logic [23:0] frame_base;
  exp_t q[$];

  vga_scan_fetch #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .FB_WIDTH(FBW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .base_address(base_address),
    .vga_address(vga_address), .vga_data(vga_data), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .frame_start(frame_start)
  );

  vga_scan_fetch u_full (
    .clk(clk), .rst_n(rst_n), .enable(f_enable), .base_address(f_base),
    .vga_address(f_vga_address), .vga_data(f_vga_data), .hsync(f_hsync), .vsync(f_vsync),
    .red(f_red), .green(f_green), .blue(f_blue), .frame_start(f_frame_start)
  );

  initial clk = 1'b0;
  initial forever #10 clk = ~clk;

  function automatic logic [15:0] ram_word(input logic [23:0] a, input logic ones);
    logic [15:0] m;
    m = a[15:0] * 16'h9E37;
    return ones ? 16'hFFFF : (m ^ 16'h3C5A);
  endfunction

  // one-clk-latency RAM models
  always @(posedge clk) vga_data   <= ram_word(vga_address, ram_ones);
  always @(posedge clk) f_vga_data <= f_vga_address[15:0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (pixel %0d,%0d frame %0d)", tag, got, exp, m_h, m_v, m_f);
    end
  endtask

  task automatic wait_pix(input int h, input int v, input int f);
    int budget;
    budget = 0;
    if (timed_out) return;
    while (!(m_h == h && m_v == v && m_f == f) && budget < WAIT_MAX) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= WAIT_MAX) begin
      timed_out = 1;
      chk("wait_timeout", 32'd1, 32'd0);
    end
  endtask

  // monitor / scoreboard: samples 1ns after every rising edge
  initial begin : mon
    exp_t        e, cur;
    int          h, v, k, fh, fv;
    logic [7:0]  exp_rgb;
    logic [15:0] d;
    logic [23:0] off, f_exp;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        if (n > 0) first_run = 0;
        n = 0;
        q.delete();
        frame_base = base_address;
        last_fs = -1;
        m_h = -1; m_v = -1; m_f = 0;
        f_low = 0;
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_rgb", 32'({red, green, blue}), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_addr", 32'(vga_address), 32'd0);
        if (first_run) chk("f_rst_addr", 32'(f_vga_address), 32'd0);
      end else begin
        n++;
        if (n % 2 == 1) begin
          chk("fs_width", 32'(frame_start), 32'd0);
        end else begin
          k = n / 2 - 1;
          h = k % HT;
          v = (k / HT) % VT;
          // outputs now show the previous pixel
          if (q.size() == 0) e = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, addr: 24'd0};
          else               e = q.pop_front();
          d = ram_word(e.addr, ram_ones);
          exp_rgb = (e.vis && enable) ? {d[15:13], d[10:8], d[4:3]} : 8'd0;
          chk("hsync", 32'(hsync), 32'(e.hs));
          chk("vsync", 32'(vsync), 32'(e.vs));
          chk("rgb", 32'({red, green, blue}), 32'(exp_rgb));
          // address for the current pixel was issued on this tick
          cur.hs  = !(h >= HV + HF && h <= HV + HF + HS - 1);
          cur.vs  = !(v >= VV + VF && v <= VV + VF + VS - 1);
          cur.vis = (h < HV) && (v < VV);
          off     = 24'((v / 4) * FBW + h / 4);
          cur.addr = frame_base + off;
          if (cur.vis) chk("addr", 32'(vga_address), 32'(cur.addr));
          chk("fs", 32'(frame_start), 32'((h == HT - 1 && v == VT - 1) ? 1 : 0));
          q.push_back(cur);
          if (h == HT - 1 && v == VT - 1) frame_base = base_address;
          if (h == 0 && v == 0 && k > 0) m_f++;
          m_h = h; m_v = v;

          if (first_run) begin
            fh = k % 800;
            fv = k / 800;
            f_exp = 24'hFFFFFF;
            if (fv == 0 && (fh == 0 || fh == 3))        f_exp = 24'h001000;
            else if (fv == 0 && fh == 4)                f_exp = 24'h001001;
            else if ((fv == 0 || fv == 3) && fh == 639) f_exp = 24'h00109F;
            else if (fv == 4 && fh == 0)                f_exp = 24'h0010A0;
            else if (fv == 5 && fh == 5)                f_exp = 24'h0010A1;
            if (f_exp != 24'hFFFFFF) chk("f_addr", 32'(f_vga_address), 32'(f_exp));
            if (fv == 0 && fh == 656) chk("f_hs_655", 32'(f_hsync), 32'd1);
            if (fv == 0 && fh == 657) chk("f_hs_656", 32'(f_hsync), 32'd0);
            if (fv == 0 && fh == 752) chk("f_hs_751", 32'(f_hsync), 32'd0);
            if (fv == 0 && fh == 753) chk("f_hs_752", 32'(f_hsync), 32'd1);
            if (k >= 1 && k <= 800 && !f_hsync) f_low++;
            if (k == 800) chk("f_hs_width", 32'(f_low), 32'd96);
            if (k == 800) chk("f_vsync", 32'(f_vsync), 32'd1);
          end
        end
        if (frame_start) begin
          if (last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 32'(2 * HT * VT));
          last_fs = cyc;
        end
      end
    end
  end

  // stimulus
  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    base_address = 24'h001000;
    ram_ones = 1'b0;
    f_enable = 1'b1;
    f_base = 24'h001000;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    // frame 0: base change mid-frame must not disturb this frame; short enable drop
    wait_pix(0, 10, 0);  base_address = 24'h002000;
    wait_pix(30, 12, 0); enable = 1'b0;
    wait_pix(40, 12, 0); enable = 1'b1;

    // frame 1 runs from 0x002000; in vblank switch to all-ones data and a wrapping base
    wait_pix(0, 25, 1);  ram_ones = 1'b1; base_address = 24'hFFFFF8;

    // frame 2: single black pixel, then reset mid-frame with a new base
    wait_pix(10, 5, 2);  enable = 1'b0;
    wait_pix(11, 5, 2);  enable = 1'b1;
    wait_pix(0, 15, 2);  base_address = 24'h003000; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // one full frame after the restart, then into the next
    wait_pix(HT - 1, VT - 1, 0);
    wait_pix(10, 2, 1);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
